// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with configurable width and depth.
// The consumer pulls words with data_2_rd. All 2**ADDR_W entries are usable.
// The block reports its occupancy (level) and almost-full/almost-empty
// thresholds.
// Optional build macro FIFO_ERR_FLAGS_EN adds the sticky overflow and
// underflow outputs.
//
// Handshake: there is no ready signal.
//   - A write (data_1_en) is accepted when the FIFO is not full, or when a read
//     is accepted in the same cycle. Otherwise the write is dropped.
//   - A read (data_2_rd) is accepted when the FIFO is not empty. Otherwise the
//     read is ignored.
//   - The popped word appears on data_2 one clock after the accepted read,
//     qualified by a one-cycle data_2_valid pulse.
//   - Producers must stall on buffer_full/almost_full.
module param_sync_fifo #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_1_en,
  input  logic [DATA_W-1:0] data_1,
  input  logic              data_2_rd,
  output logic              buffer_empty,
  output logic              buffer_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              data_2_valid,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [DATA_W-1:0] data_2
);

  // Thresholds sized to the level counter so comparisons stay width-matched.
  localparam logic [ADDR_W:0] DEPTH_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_LVL    = AF_LEVEL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_LVL    = AE_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Status flags depend on level only, so they follow the edge that moved it.
  assign buffer_empty = (level == '0);
  assign buffer_full  = (level == DEPTH_LVL);
  assign almost_empty = (level <= AE_LVL);
  assign almost_full  = (level >= AF_LVL);

  // A read frees a slot, so a write into a full FIFO may proceed alongside it.
  // There is no bypass: a write into an empty FIFO cannot satisfy a read in
  // the same cycle.
  assign rd_ok = data_2_rd & ~buffer_empty;
  assign wr_ok = data_1_en & (~buffer_full | rd_ok);

  // Storage write; contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_1;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      data_2       <= '0;
      data_2_valid <= 1'b0;
    end else begin
      data_2_valid <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_2 <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_ok && !rd_ok)      level <= level + 1'b1;
      else if (rd_ok && !wr_ok) level <= level - 1'b1;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags for requests that were dropped; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (data_1_en && buffer_full && !rd_ok) overflow  <= 1'b1;
      if (data_2_rd && buffer_empty)          underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed testbench for param_sync_fifo at default parameters (16 x 8).
module tb_param_sync_fifo;

  logic        clk;
  logic        rst_n;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        data_2_rd;
  logic        buffer_empty;
  logic        buffer_full;
  logic        almost_empty;
  logic        almost_full;
  logic [3:0]  level;
  logic        data_2_valid;
  logic [15:0] data_2;
`ifdef FIFO_ERR_FLAGS_EN
  logic        overflow;
  logic        underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  param_sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_1_en    (data_1_en),
    .data_1       (data_1),
    .data_2_rd    (data_2_rd),
    .buffer_empty (buffer_empty),
    .buffer_full  (buffer_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .data_2_valid (data_2_valid),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .data_2       (data_2)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of requests, return 1 time unit after the edge.
  task automatic cyc(input logic en, input logic [15:0] d, input logic rd);
    data_1_en = en;
    data_1    = d;
    data_2_rd = rd;
    @(posedge clk);
    #1;
    data_1_en = 1'b0;
    data_2_rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; data_1_en = 1'b0; data_1 = '0; data_2_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    chk("rst_empty", buffer_empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_full", buffer_full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", data_2_valid, 0);
    chk("rst_data", data_2, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write 1,2,3 then read three times
    cyc(1, 16'd1, 0); cyc(1, 16'd2, 0); cyc(1, 16'd3, 0);
    chk("w3_level", level, 3);
    chk("w3_ae", almost_empty, 0);
    chk("w3_empty", buffer_empty, 0);
    cyc(0, 0, 1);
    chk("r1_valid", data_2_valid, 1);
    chk("r1_data", data_2, 16'd1);
    chk("r1_level", level, 2);
    chk("r1_ae", almost_empty, 1);
    cyc(0, 0, 0);
    chk("idle_valid", data_2_valid, 0);
    chk("idle_hold", data_2, 16'd1);
    cyc(0, 0, 1);
    chk("r2_data", data_2, 16'd2);
    chk("r2_valid", data_2_valid, 1);
    cyc(0, 0, 1);
    chk("r3_data", data_2, 16'd3);
    chk("r3_level", level, 0);
    chk("r3_empty", buffer_empty, 1);

    // Fill with 0x0010..0x0017
    for (int i = 0; i < 8; i++) begin
      cyc(1, 16'h0010 + 16'(i), 0);
      if (i == 4) chk("l5_af", almost_full, 0);
      if (i == 5) chk("l6_af", almost_full, 1);
    end
    chk("fill_level", level, 8);
    chk("fill_full", buffer_full, 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("pre_ovf", overflow, 0);
`endif
    cyc(1, 16'hFFFF, 0);
    chk("drop_level", level, 8);
    chk("drop_valid", data_2_valid, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", overflow, 1);
`endif
    // Write and read together while full
    cyc(1, 16'h00AA, 1);
    chk("fullrw_data", data_2, 16'h0010);
    chk("fullrw_valid", data_2_valid, 1);
    chk("fullrw_level", level, 8);
    chk("fullrw_full", buffer_full, 1);
    // Drain: 0x11..0x17 then 0xAA, never 0xFFFF
    for (int i = 1; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("drain_data", data_2, 16'h0010 + 16'(i));
    end
    cyc(0, 0, 1);
    chk("drain_last", data_2, 16'h00AA);
    chk("drain_level", level, 0);
    chk("drain_empty", buffer_empty, 1);

    // Write and read together while empty: no bypass
`ifdef FIFO_ERR_FLAGS_EN
    chk("pre_unf", underflow, 0);
`endif
    cyc(1, 16'h0005, 1);
    chk("emprw_valid", data_2_valid, 0);
    chk("emprw_hold", data_2, 16'h00AA);
    chk("emprw_level", level, 1);
    cyc(0, 0, 1);
    chk("emprw_data", data_2, 16'h0005);
    chk("emprw_valid2", data_2_valid, 1);
    cyc(0, 0, 1);
    chk("rdempty_valid", data_2_valid, 0);
    chk("rdempty_hold", data_2, 16'h0005);
    chk("rdempty_level", level, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("unf_set", underflow, 1);
`endif

    // Interleaved traffic across pointer wrap, scoreboarded
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h0200 + 16'(i), 0);
      exp_q.push_back(16'h0200 + 16'(i));
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1, 16'h0100 + 16'(i), 1);
      exp_q.push_back(16'h0100 + 16'(i));
      exp_w = exp_q.pop_front();
      chk("wrap_data", data_2, 32'(exp_w));
      chk("wrap_valid", data_2_valid, 1);
      chk("wrap_level", level, 3);
    end
    while (exp_q.size() > 0) begin
      cyc(0, 0, 1);
      exp_w = exp_q.pop_front();
      chk("wrap_drain", data_2, 32'(exp_w));
    end
    chk("wrap_empty", buffer_empty, 1);

    // Asynchronous reset mid-cycle with level = 5
    for (int i = 0; i < 6; i++) cyc(1, 16'h0300 + 16'(i), 0);
    cyc(0, 0, 1);
    chk("pre_arst_level", level, 5);
    chk("pre_arst_valid", data_2_valid, 1);
    chk("pre_arst_data", data_2, 16'h0300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", buffer_empty, 1);
    chk("arst_ae", almost_empty, 1);
    chk("arst_valid", data_2_valid, 0);
    chk("arst_data", data_2, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("arst_ovf", overflow, 0);
    chk("arst_unf", underflow, 0);
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, 1);
    chk("post_rd_valid", data_2_valid, 0);
    chk("post_rd_level", level, 0);
    cyc(1, 16'h0077, 0);
    cyc(0, 0, 1);
    chk("post_wr_data", data_2, 16'h0077);
    chk("post_wr_valid", data_2_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
